booth_multiplier: RTL and testbench

- Sequential radix-2 Booth multiplier for two's-complement signed operands.
- While reset is high, the operands are captured. After reset is released, one Booth step runs per clock. The signed 2*WIDTH-bit product is registered on the WIDTH-th step.
- Used as a small multi-cycle arithmetic unit. Reset doubles as the load/start control.

---
 rtl/booth_multiplier.sv | 98 +++++++++
 tb/tb_booth_multiplier.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: reset loads x/y, then one Booth step per clk; product registered on step WIDTH.
// Optional BOOTH_MULT_DONE_EN adds a 'done' flag that is high from the product-write edge until the next reset.
module booth_multiplier #(
    parameter int WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [WIDTH-1:0]   x,
    input  logic signed [WIDTH-1:0]   y,
`ifdef BOOTH_MULT_DONE_EN
    output logic signed [2*WIDTH-1:0] product,
    output logic                      done
`else
    output logic signed [2*WIDTH-1:0] product
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q1_q, q1_d;
    logic [WIDTH:0]     m_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH+1:0]   shifted;

    // Add/subtract selected by the current and previous multiplier bits, then
    // arithmetic shift of the whole {A,Q,Q_1} register.
    always_comb begin
        sum = a_q;
        case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
        shifted = {sum[WIDTH], sum, q_q};
    end

    always_comb begin
        a_d    = a_q;
        q_d    = q_q;
        q1_d   = q1_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        prod_d = prod_q;
        if (busy_q) begin
            a_d   = shifted[2*WIDTH+1:WIDTH+1];
            q_d   = shifted[WIDTH:1];
            q1_d  = shifted[0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                prod_d = {shifted[2*WIDTH:WIDTH+1], shifted[WIDTH:1]};
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            q_q    <= y;
            q1_q   <= 1'b0;
            m_q    <= {x[WIDTH-1], x};
            cnt_q  <= '0;
            busy_q <= 1'b1;
            prod_q <= '0;
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            q1_q   <= q1_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            prod_q <= prod_d;
        end
    end

    assign product = prod_q;

`ifdef BOOTH_MULT_DONE_EN
    logic done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else if (busy_q && cnt_q == LAST) begin
            done_q <= 1'b1;
        end
    end

    assign done = done_q;
`endif

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier: per-cycle compare against a cycle-count/product model, plus literal anchors.
module tb_booth_multiplier;

    localparam int W = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic signed [W-1:0] x, y;
    logic [2*W-1:0]      product;
`ifdef BOOTH_MULT_DONE_EN
    logic                done;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Model state: operands seen at the last reset-high edge and edges elapsed since.
    logic signed [W-1:0] cap_x, cap_y;
    int                  steps = 0;
    bit                  mvalid = 0;

    always #5 clk = ~clk;

    booth_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .x       (x),
        .y       (y),
`ifdef BOOTH_MULT_DONE_EN
        .product (product),
        .done    (done)
`else
        .product (product)
`endif
    );

    task automatic check(input string nm, input logic [2*W-1:0] got, input logic [2*W-1:0] expv);
        compared++;
        if (got !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, expv, $time);
        end
    endtask

    // One clock: update the model on the rising edge, compare on the falling edge.
    task automatic cycle();
        int full;
        logic [2*W-1:0] expv;
        @(posedge clk);
        if (reset) begin
            cap_x  = x;
            cap_y  = y;
            steps  = 0;
            mvalid = 1;
        end else if (steps < W) begin
            steps++;
        end
        @(negedge clk);
        if (mvalid) begin
            full = int'(cap_x) * int'(cap_y);
            expv = (steps == W) ? full[2*W-1:0] : '0;
            check("model_product", product, expv);
`ifdef BOOTH_MULT_DONE_EN
            check("model_done", {{(2*W-1){1'b0}}, done}, {{(2*W-1){1'b0}}, (steps == W)});
`endif
        end
    endtask

    task automatic start(input int xv, input int yv, input int nrst);
        reset = 1'b1;
        x = xv[W-1:0];
        y = yv[W-1:0];
        repeat (nrst) cycle();
        reset = 1'b0;
    endtask

    typedef struct { int xv; int yv; logic [2*W-1:0] expv; string nm; } vec_t;
    vec_t vecs[3];

    initial begin
        vecs[0] = '{-5, 3, 12'hFF1, "neg5_x_3"};
        vecs[1] = '{31, -32, 12'hC20, "31_x_neg32"};
        vecs[2] = '{-32, -32, 12'h400, "neg32_x_neg32"};

        // Basic multiply with a two-cycle reset.
        reset = 1'b1;
        x = 6'd7;
        y = 6'd2;
        cycle();
        check("reset_state", product, 12'h000);
        cycle();
        reset = 1'b0;
        repeat (5) cycle();
        check("basic_before_6th_edge", product, 12'h000);
`ifdef BOOTH_MULT_DONE_EN
        check("done_low_step5", {11'b0, done}, 12'h000);
`endif
        cycle();
        check("basic_7x2", product, 12'h00E);
`ifdef BOOTH_MULT_DONE_EN
        check("done_high_step6", {11'b0, done}, 12'h001);
`endif

        // Back-to-back multiply, then idle hold.
        start(7, 7, 1);
        repeat (6) cycle();
        check("b2b_7x7", product, 12'h031);
        repeat (4) cycle();
        check("b2b_hold", product, 12'h031);

        // Signed corner cases.
        foreach (vecs[i]) begin
            start(vecs[i].xv, vecs[i].yv, 1);
            repeat (6) cycle();
            check(vecs[i].nm, product, vecs[i].expv);
        end

        // Reset reasserted after three steps aborts and reloads.
        start(7, 7, 1);
        repeat (3) cycle();
        reset = 1'b1;
        x = 6'd3;
        y = 6'd5;
        cycle();
        check("midop_reset_zero", product, 12'h000);
`ifdef BOOTH_MULT_DONE_EN
        check("midop_done_low", {11'b0, done}, 12'h000);
`endif
        reset = 1'b0;
        repeat (6) cycle();
        check("midop_3x5", product, 12'h00F);

        // Operands wiggle every cycle while running; result uses captured values.
        start(-7, 9, 1);
        for (int k = 0; k < 8; k++) begin
            x = 6'($urandom);
            y = 6'($urandom);
            cycle();
        end
        check("isolation_neg7x9", product, 12'hFC1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
